dco_code_ctrl: RTL and testbench

Digital loop controller that sits directly upstream of the DCO in the ADPLL. It consumes the phase/frequency detector's UP/DN decisions on the reference clock and produces the 129-bit thermometer control word the DCO decodes into an oscillation period. Operation is two-phase:
- coarse binary-search frequency acquisition;
- ±1 LSB phase tracking with lock detection.

---
 rtl/dco_code_ctrl_pkg.sv | 32 +++
 rtl/dco_code_ctrl_therm_enc.sv | 14 +
 rtl/dco_code_ctrl.sv | 133 +++++++++++++
 tb/tb_dco_code_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dco_code_ctrl_pkg.sv
// Shared widths, code levels, FSM states and PFD decision encodings for the
// ADPLL DCO code controller and its thermometer encoder.
package dco_code_ctrl_pkg;

   localparam int CODE_W = 129;
   localparam int IDX_W  = 8;

   localparam logic [IDX_W-1:0] IDX_MAX = 8'd128;
   localparam logic [IDX_W-1:0] IDX_MID = 8'd64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACQ   = 2'd1,
      ST_TRACK = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      DEC_HOLD = 2'd0,
      DEC_INC  = 2'd1,
      DEC_DEC  = 2'd2
   } dec_t;

   // Conflicting or absent PFD pulses both mean "no correction".
   function automatic dec_t decode_pfd(input logic up, input logic dn);
      case ({up, dn})
         2'b10:   return DEC_INC;
         2'b01:   return DEC_DEC;
         default: return DEC_HOLD;
      endcase
   endfunction

endpackage

// File: rtl/dco_code_ctrl_therm_enc.sv
// Combinational code level to thermometer word: bit i is set iff i < idx.
// Kept separate so a later dithering stage can reuse it.
module therm_enc
   import dco_code_ctrl_pkg::*;
(
   input  logic [IDX_W-1:0]  idx,
   output logic [CODE_W-1:0] code
);

   for (genvar i = 0; i < CODE_W; i++) begin : g_bit
      assign code[i] = (idx > IDX_W'(i));
   end

endmodule

// File: rtl/dco_code_ctrl.sv
// ADPLL loop controller: binary-search acquisition followed by +/-1 LSB
// tracking with lock detection, driving a registered thermometer DCO word.
module dco_code_ctrl
   import dco_code_ctrl_pkg::*;
#(
   parameter int SETTLE   = 2,
   parameter int LOCK_CNT = 8
) (
   input  logic              REF_CLK,
   input  logic              RESET_N,
   input  logic              EN,
   input  logic              UP,
   input  logic              DN,
   output logic [CODE_W-1:0] CODE,
   output logic [IDX_W-1:0]  CODE_IDX,
   output logic              LOCK,
   output logic [1:0]        STATE
);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic                lock_q, lock_d;
   logic [5:0]          step_q, step_d;
   logic [3:0]          wait_q, wait_d;
   logic [7:0]          lcnt_q, lcnt_d;
   dec_t                last_q, last_d;
   dec_t                dec;
   logic [7:0]          lcnt_inc;

   assign dec      = decode_pfd(UP, DN);
   assign lcnt_inc = (lcnt_q == 8'(LOCK_CNT)) ? lcnt_q : lcnt_q + 8'd1;

   // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      step_d  = step_q;
      wait_d  = wait_q;
      lcnt_d  = lcnt_q;
      last_d  = last_q;
      if (!EN) begin
         state_d = ST_IDLE;
         lcnt_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ACQ;
               idx_d   = IDX_MID;
               step_d  = 6'd32;
               wait_d  = 4'(SETTLE);
               lcnt_d  = '0;
               last_d  = DEC_HOLD;
            end
            ST_ACQ: begin
               if (wait_q != 4'd0) begin
                  wait_d = wait_q - 4'd1;
               end else begin
                  wait_d = 4'(SETTLE);
                  step_d = step_q >> 1;
                  case (dec)
                     DEC_INC: idx_d = idx_q + {2'b00, step_q};
                     DEC_DEC: idx_d = idx_q - {2'b00, step_q};
                     default: ;
                  endcase
                  if (step_q == 6'd1) begin
                     state_d = ST_TRACK;
                     last_d  = DEC_HOLD;
                     lcnt_d  = '0;
                  end
               end
            end
            ST_TRACK: begin
               if (wait_q != 4'd0) begin
                  wait_d = wait_q - 4'd1;
               end else begin
                  wait_d = 4'(SETTLE);
                  // A repeated direction means we are still slewing, not dithering around lock.
                  case (dec)
                     DEC_INC: begin
                        if (idx_q != IDX_MAX) idx_d = idx_q + 8'd1;
                        lcnt_d = (last_q == DEC_INC) ? 8'd0 : lcnt_inc;
                        last_d = DEC_INC;
                     end
                     DEC_DEC: begin
                        if (idx_q != 8'd0) idx_d = idx_q - 8'd1;
                        lcnt_d = (last_q == DEC_DEC) ? 8'd0 : lcnt_inc;
                        last_d = DEC_DEC;
                     end
                     default: lcnt_d = lcnt_inc;
                  endcase
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      lock_d = (state_d == ST_TRACK) && (lcnt_d == 8'(LOCK_CNT));
   end

   therm_enc u_therm_enc (
      .idx  (idx_d),
      .code (code_d)
   );

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge REF_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         code_q  <= '0;
         lock_q  <= 1'b0;
         step_q  <= '0;
         wait_q  <= '0;
         lcnt_q  <= '0;
         last_q  <= DEC_HOLD;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         code_q  <= code_d;
         lock_q  <= lock_d;
         step_q  <= step_d;
         wait_q  <= wait_d;
         lcnt_q  <= lcnt_d;
         last_q  <= last_d;
      end
   end

   assign CODE     = code_q;
   assign CODE_IDX = idx_q;
   assign LOCK     = lock_q;
   assign STATE    = state_q;

endmodule

// File: tb/tb_dco_code_ctrl.sv
// Self-checking bench for dco_code_ctrl: directed acquisition/lock/interrupt
// steps plus a random phase, all checked against an arithmetic loop model.
module tb_dco_code_ctrl;

   localparam int SETTLE   = 2;
   localparam int LOCK_CNT = 8;

   logic         REF_CLK = 1'b0;
   logic         RESET_N = 1'b0;
   logic         EN = 1'b0;
   logic         UP = 1'b0;
   logic         DN = 1'b0;
   logic [128:0] CODE;
   logic [7:0]   CODE_IDX;
   logic         LOCK;
   logic [1:0]   STATE;

   int checks = 0;
   int errors = 0;

   // Reference model: state 0/1/2, code level, search step, settle countdown,
   // lock count, last move direction (+1, -1, 0 = none).
   int m_state, m_idx, m_step, m_wait, m_lcnt, m_last;
   bit m_lock;

   always #5 REF_CLK = ~REF_CLK;

   dco_code_ctrl #(.SETTLE(SETTLE), .LOCK_CNT(LOCK_CNT)) dut (
      .REF_CLK  (REF_CLK),
      .RESET_N  (RESET_N),
      .EN       (EN),
      .UP       (UP),
      .DN       (DN),
      .CODE     (CODE),
      .CODE_IDX (CODE_IDX),
      .LOCK     (LOCK),
      .STATE    (STATE)
   );

   function automatic logic [128:0] therm(input int n);
      logic [128:0] one;
      one = 129'd1;
      return (one << n) - one;
   endfunction

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".state"}, 160'(STATE), 160'(m_state));
      check({tag, ".idx"},   160'(CODE_IDX), 160'(m_idx));
      check({tag, ".code"},  160'(CODE), 160'(therm(m_idx)));
      check({tag, ".lock"},  160'(LOCK), 160'(m_lock));
   endtask

   task automatic model_reset();
      m_state = 0; m_idx = 0; m_step = 0; m_wait = 0;
      m_lcnt = 0; m_last = 0; m_lock = 0;
   endtask

   task automatic model_edge(input bit en, input bit up, input bit dn);
      int d;
      d = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
      if (!en) begin
         m_state = 0; m_lock = 0; m_lcnt = 0;
      end else if (m_state == 0) begin
         m_state = 1; m_idx = 64; m_step = 32; m_wait = SETTLE; m_lock = 0;
         m_lcnt = 0; m_last = 0;
      end else if (m_wait > 0) begin
         m_wait--;
      end else begin
         m_wait = SETTLE;
         if (m_state == 1) begin
            m_idx += d * m_step;
            if (m_step == 1) begin
               m_state = 2; m_last = 0; m_lcnt = 0;
            end
            m_step /= 2;
         end else begin
            if (d != 0) begin
               m_idx += d;
               if (m_idx > 128) m_idx = 128;
               if (m_idx < 0) m_idx = 0;
               m_lcnt = (d == m_last) ? 0 : ((m_lcnt < LOCK_CNT) ? m_lcnt + 1 : LOCK_CNT);
               m_last = d;
            end else begin
               m_lcnt = (m_lcnt < LOCK_CNT) ? m_lcnt + 1 : LOCK_CNT;
            end
         end
         m_lock = (m_state == 2) && (m_lcnt == LOCK_CNT);
      end
   endtask

   task automatic cycle(input string tag);
      @(posedge REF_CLK);
      if (!RESET_N) model_reset();
      else model_edge(EN, UP, DN);
      #1;
      check_all(tag);
   endtask

   task automatic decision(input bit up, input bit dn, input string tag);
      UP = up;
      DN = dn;
      repeat (SETTLE + 1) cycle(tag);
   endtask

   initial begin
      model_reset();

      // Reset held with random inputs
      repeat (4) begin
         EN = 1'($urandom); UP = 1'($urandom); DN = 1'($urandom);
         cycle("reset");
      end
      RESET_N = 1'b1; EN = 1'b0; UP = 1'b0; DN = 1'b0;
      cycle("idle");

      // Acquire up
      EN = 1'b1; UP = 1'b1; DN = 1'b0;
      cycle("acq_up_entry");
      check("acq_up_entry_idx", 160'(CODE_IDX), 160'(64));
      repeat (18) cycle("acq_up");
      check("acq_up_end_idx", 160'(CODE_IDX), 160'(127));
      check("acq_up_end_state", 160'(STATE), 160'(2));
      repeat (3 * (SETTLE + 1)) cycle("track_up_sat");
      check("up_sat_idx", 160'(CODE_IDX), 160'(128));
      check("up_sat_code", 160'(CODE), 160'(therm(128)));
      check("up_sat_lock", 160'(LOCK), 160'(0));

      EN = 1'b0;
      cycle("en_drop_top");
      check("en_drop_top_idx", 160'(CODE_IDX), 160'(128));

      // Acquire down
      EN = 1'b1; UP = 1'b0; DN = 1'b1;
      cycle("acq_dn_entry");
      repeat (18) cycle("acq_dn");
      check("acq_dn_end_idx", 160'(CODE_IDX), 160'(1));
      check("acq_dn_end_state", 160'(STATE), 160'(2));
      repeat (3 * (SETTLE + 1)) cycle("track_dn_sat");
      check("dn_sat_idx", 160'(CODE_IDX), 160'(0));
      check("dn_sat_code", 160'(CODE), 160'(0));
      check("dn_sat_lock", 160'(LOCK), 160'(0));

      // Random acquisition, then lock by alternating decisions
      EN = 1'b0;
      cycle("restart_idle");
      EN = 1'b1;
      cycle("restart_acq");
      repeat (6) decision(1'($urandom), 1'($urandom), "acq_rand");
      check("lock_track_state", 160'(STATE), 160'(2));
      for (int k = 0; k < 7; k++) decision(k % 2 == 0, k % 2 == 1, "alt");
      check("lock_after7", 160'(LOCK), 160'(0));
      decision(1'b0, 1'b1, "alt8");
      check("lock_after8", 160'(LOCK), 160'(1));
      decision(1'b1, 1'b0, "up1");
      check("lock_up1", 160'(LOCK), 160'(1));
      decision(1'b1, 1'b0, "up2");
      check("lock_up2", 160'(LOCK), 160'(0));

      // Hold decisions: both asserted, then neither
      repeat (7) decision(1'b1, 1'b1, "hold11");
      check("hold11_lock7", 160'(LOCK), 160'(0));
      repeat (3) decision(1'b1, 1'b1, "hold11");
      check("hold11_lock", 160'(LOCK), 160'(1));
      decision(1'b1, 1'b0, "break");
      check("break_lock", 160'(LOCK), 160'(0));
      repeat (10) decision(1'b0, 1'b0, "hold00");
      check("hold00_lock", 160'(LOCK), 160'(1));

      // EN dropped in TRACK, then re-raised
      EN = 1'b0;
      cycle("en_drop_track");
      check("en_drop_track_state", 160'(STATE), 160'(0));
      check("en_drop_track_lock", 160'(LOCK), 160'(0));
      EN = 1'b1;
      cycle("en_reraise");
      check("en_reraise_idx", 160'(CODE_IDX), 160'(64));

      // Asynchronous reset mid-ACQ
      UP = 1'b1; DN = 1'b0;
      repeat (4) cycle("pre_async");
      #3 RESET_N = 1'b0;
      #1;
      model_reset();
      check("async_code", 160'(CODE), 160'(0));
      check("async_idx", 160'(CODE_IDX), 160'(0));
      check("async_state", 160'(STATE), 160'(0));
      check("async_lock", 160'(LOCK), 160'(0));
      #3 RESET_N = 1'b1;
      cycle("post_async");
      check("post_async_idx", 160'(CODE_IDX), 160'(64));

      // Random phase
      repeat (400) begin
         EN = ($urandom_range(0, 63) != 0);
         UP = 1'($urandom);
         DN = 1'($urandom);
         cycle("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
